// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller: long-latency register scoreboard, load-use/RAW/WAW/structural
// stall detection, priority forwarding, multi-cycle flush hold and a saturating stall counter.
module hazard_scoreboard_unit #(
  parameter int unsigned NREGS     = 32,
  parameter int unsigned NFWD      = 2,
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned MAX_PEND  = 4,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned AW       = $clog2(NREGS),
  localparam int unsigned FWD_W    = $clog2(NFWD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AW-1:0]      rs1_addr_id,
  input  logic [AW-1:0]      rs2_addr_id,
  input  logic               rs1_used_id,
  input  logic               rs2_used_id,
  input  logic [AW-1:0]      rd_addr_id,
  input  logic               reg_write_id,
  input  logic               long_op_id,
  input  logic [AW-1:0]      rd_addr_ex,
  input  logic               reg_write_ex,
  input  logic               mem_read_ex,
  input  logic               long_issue_ex,
  input  logic [NFWD*AW-1:0] fwd_rd_addr,
  input  logic [NFWD-1:0]    fwd_reg_write,
  input  logic               long_done,
  input  logic [AW-1:0]      long_done_rd,
  input  logic               branch_taken,
  input  logic               jump_taken,
  output logic               stall,
  output logic               flush,
  output logic [FWD_W-1:0]   forward_a,
  output logic [FWD_W-1:0]   forward_b,
  output logic               if_id_enable,
  output logic               id_ex_enable,
  output logic               pend_full,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned PW  = $clog2(MAX_PEND + 1);
  localparam int unsigned FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [PW-1:0]    pend_cnt_q, pend_cnt_d;
  logic [FCW-1:0]   flush_ctr_q, flush_ctr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic set_busy, clr_busy, redirect;
  logic load_use, raw_hzd, waw_hzd, struct_hzd;

  // Lowest-numbered (youngest) matching stage wins, so iterate oldest first.
  always_comb begin
    forward_a = '0;
    forward_b = '0;
    for (int k = int'(NFWD) - 1; k >= 0; k--) begin
      if (fwd_reg_write[k] && fwd_rd_addr[k*AW +: AW] != '0) begin
        if (rs1_used_id && fwd_rd_addr[k*AW +: AW] == rs1_addr_id) forward_a = FWD_W'(k + 1);
        if (rs2_used_id && fwd_rd_addr[k*AW +: AW] == rs2_addr_id) forward_b = FWD_W'(k + 1);
      end
    end
  end

  always_comb begin
    set_busy = long_issue_ex && reg_write_ex && (rd_addr_ex != '0);
    clr_busy = long_done && busy_q[long_done_rd];

    // Clear first so a simultaneous set of the same register wins.
    busy_d = busy_q;
    if (clr_busy) busy_d[long_done_rd] = 1'b0;
    if (set_busy) busy_d[rd_addr_ex] = 1'b1;
    busy_d[0] = 1'b0;

    pend_cnt_d = pend_cnt_q;
    if (set_busy && !clr_busy && pend_cnt_q != PW'(MAX_PEND)) pend_cnt_d = pend_cnt_q + 1'b1;
    else if (clr_busy && !set_busy && pend_cnt_q != '0)      pend_cnt_d = pend_cnt_q - 1'b1;
  end

  always_comb begin
    pend_full  = (pend_cnt_q == PW'(MAX_PEND));
    load_use   = mem_read_ex && (rd_addr_ex != '0) &&
                 ((rs1_used_id && rs1_addr_id == rd_addr_ex) ||
                  (rs2_used_id && rs2_addr_id == rd_addr_ex));
    raw_hzd    = (busy_q[rs1_addr_id] && rs1_used_id) || (busy_q[rs2_addr_id] && rs2_used_id);
    waw_hzd    = reg_write_id && busy_q[rd_addr_id];
    struct_hzd = long_op_id && pend_full;

    redirect     = branch_taken || jump_taken;
    flush        = redirect || (flush_ctr_q != '0);
    stall        = (load_use || raw_hzd || waw_hzd || struct_hzd) && !flush;
    if_id_enable = !stall;
    id_ex_enable = !stall;
    stall_cnt    = stall_cnt_q;

    flush_ctr_d = flush_ctr_q;
    if (redirect)                flush_ctr_d = FCW'(FLUSH_CYC - 1);
    else if (flush_ctr_q != '0)  flush_ctr_d = flush_ctr_q - 1'b1;

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      pend_cnt_q  <= '0;
      flush_ctr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      pend_cnt_q  <= pend_cnt_d;
      flush_ctr_q <= flush_ctr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
